// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller: state encoding,
// digit geometry, board-clock timing defaults and the leading-zero blanking rule.
package seg_scan_ctrl_pkg;

   localparam int unsigned NUM_DIGITS   = 4;
   localparam int unsigned DIGIT_W      = 4;
   localparam int unsigned SEL_W        = $clog2(NUM_DIGITS);
   localparam int unsigned DEF_PRESCALE = 100000;
   localparam int unsigned DEF_BLANK    = 2000;

   typedef enum logic [1:0] {
      S_OFF,
      S_BLANK,
      S_DRIVE
   } scan_state_e;

   typedef struct packed {
      logic                                lzb;
      logic [NUM_DIGITS-1:0]               dp;
      logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  data;
   } snapshot_t;

   // A digit is blanked only when it and every more-significant digit are zero.
   function automatic logic digit_blanked(input snapshot_t snap, input logic [SEL_W-1:0] sel);
      logic blanked;
      blanked = 1'b0;
      if (snap.lzb) begin
         case (sel)
            2'd3:    blanked = (snap.data[3] == '0);
            2'd2:    blanked = (snap.data[3] == '0) && (snap.data[2] == '0);
            2'd1:    blanked = (snap.data[3] == '0) && (snap.data[2] == '0) &&
                               (snap.data[1] == '0);
            default: blanked = 1'b0;
         endcase
      end
      return blanked;
   endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot counter: counts 0..PRESCALE-1 while enabled, otherwise held at 0,
// and flags the end of the blank phase and the end of the slot.
module scan_slot_timer
   import seg_scan_ctrl_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE,
   parameter int unsigned BLANK    = DEF_BLANK
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_blank_done,
   output logic o_slot_done,
   output logic o_slot_last_next
);

   localparam int unsigned   CW         = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST       = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK == 0) ? 0 : BLANK - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign o_slot_done      = (cnt_q == LAST);
   assign o_blank_done     = (BLANK == 0) || (cnt_q == BLANK_LAST);
   // Lets the parent register outputs that must line up with the last slot cycle.
   assign o_slot_last_next = (cnt_d == LAST);

   always_comb begin
      cnt_d = '0;
      if (i_en && !o_slot_done) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller: steps digit select with a blanking gap,
// snapshots display data once per frame and applies leading-zero blanking.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE,
   parameter int unsigned BLANK    = DEF_BLANK
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_run,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] i_data,
   input  logic [NUM_DIGITS-1:0]         i_dp,
   input  logic                          i_lzb,
   output logic [SEL_W-1:0]              o_sel,
   output logic                          o_ena,
   output logic [DIGIT_W-1:0]            o_digit,
   output logic                          o_dp,
   output logic                          o_frame
);

   localparam scan_state_e SLOT_ENTRY = (BLANK == 0) ? S_DRIVE : S_BLANK;
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

   scan_state_e      state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   snapshot_t        snap_q, snap_d;
   logic             snap_load;
   logic             blank_done, slot_done, slot_last_next;

   scan_slot_timer #(
      .PRESCALE (PRESCALE),
      .BLANK    (BLANK)
   ) u_timer (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_en             (i_run && (state_q != S_OFF)),
      .o_blank_done     (blank_done),
      .o_slot_done      (slot_done),
      .o_slot_last_next (slot_last_next)
   );

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      snap_load = 1'b0;
      if (!i_run) begin
         state_d = S_OFF;
         sel_d   = '0;
      end else begin
         unique case (state_q)
            S_OFF: begin
               state_d   = SLOT_ENTRY;
               sel_d     = '0;
               snap_load = 1'b1;
            end
            S_BLANK: begin
               if (blank_done) state_d = S_DRIVE;
            end
            S_DRIVE: begin
               if (slot_done) begin
                  state_d   = SLOT_ENTRY;
                  sel_d     = sel_q + SEL_W'(1);
                  snap_load = (sel_q == LAST_SEL);
               end
            end
            default: state_d = S_OFF;
         endcase
      end
      snap_d = snap_q;
      if (snap_load) begin
         snap_d.lzb  = i_lzb;
         snap_d.dp   = i_dp;
         snap_d.data = i_data;
      end
   end

   assign o_sel = sel_q;

   // Outputs are registered from next-state so they track the state register exactly.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_OFF;
         sel_q   <= '0;
         snap_q  <= '0;
         o_ena   <= 1'b0;
         o_digit <= '0;
         o_dp    <= 1'b0;
         o_frame <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         snap_q  <= snap_d;
         o_ena   <= (state_d == S_DRIVE) && !digit_blanked(snap_d, sel_d);
         o_digit <= snap_d.data[sel_d];
         o_dp    <= snap_d.dp[sel_d];
         o_frame <= (state_d == S_DRIVE) && (sel_d == LAST_SEL) && slot_last_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with BLANK=2 and one with BLANK=0,
// both PRESCALE=8, driven by identical stimulus.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [15:0] data;
   logic [3:0]  dp;
   logic        lzb;

   logic [1:0]  a_sel, b_sel;
   logic        a_ena, b_ena;
   logic [3:0]  a_digit, b_digit;
   logic        a_dp, b_dp;
   logic        a_frame, b_frame;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.PRESCALE(8), .BLANK(2)) dut_a (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_run   (run),
      .i_data  (data),
      .i_dp    (dp),
      .i_lzb   (lzb),
      .o_sel   (a_sel),
      .o_ena   (a_ena),
      .o_digit (a_digit),
      .o_dp    (a_dp),
      .o_frame (a_frame)
   );

   seg_scan_ctrl #(.PRESCALE(8), .BLANK(0)) dut_b (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_run   (run),
      .i_data  (data),
      .i_dp    (dp),
      .i_lzb   (lzb),
      .o_sel   (b_sel),
      .o_ena   (b_ena),
      .o_digit (b_digit),
      .o_dp    (b_dp),
      .o_frame (b_frame)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " a_sel"}, a_sel, 0);
      check({tag, " a_ena"}, a_ena, 0);
      check({tag, " a_frame"}, a_frame, 0);
      check({tag, " b_ena"}, b_ena, 0);
      check({tag, " b_frame"}, b_frame, 0);
   endtask

   // Starts at slot 0 cnt 0; checks one full frame and ends at the next frame's cnt 0.
   // At slot 1 cnt 3 the inputs switch to nd/ndp/nlzb (what the next frame latches).
   task automatic frame_check(input string tag, input logic [15:0] d_exp,
                              input logic [3:0] dp_exp, input logic [3:0] lit_exp,
                              input logic [15:0] nd, input logic [3:0] ndp,
                              input logic nlzb);
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 8; c++) begin
            string t;
            logic [3:0] dig;
            t   = $sformatf("%s s%0d c%0d", tag, s, c);
            dig = d_exp[s*4 +: 4];
            check({t, " a_sel"}, a_sel, s[1:0]);
            check({t, " a_ena"}, a_ena, (c >= 2) && lit_exp[s]);
            check({t, " a_digit"}, a_digit, dig);
            check({t, " a_dp"}, a_dp, dp_exp[s]);
            check({t, " a_frame"}, a_frame, (s == 3) && (c == 7));
            check({t, " b_sel"}, b_sel, s[1:0]);
            check({t, " b_ena"}, b_ena, lit_exp[s]);
            check({t, " b_dp"}, b_dp, dp_exp[s]);
            check({t, " b_frame"}, b_frame, (s == 3) && (c == 7));
            if (s == 1 && c == 3) begin
               data = nd;
               dp   = ndp;
               lzb  = nlzb;
            end
            step();
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      run  = 1'b0;
      data = 16'h1234;
      dp   = 4'b0000;
      lzb  = 1'b0;
      step();
      step();
      check("rst a_sel", a_sel, 0);
      check("rst a_ena", a_ena, 0);
      check("rst a_digit", a_digit, 0);
      check("rst a_dp", a_dp, 0);
      check("rst a_frame", a_frame, 0);
      check("rst b_ena", b_ena, 0);

      rst = 1'b0;
      step();
      check_idle("off");

      // Basic scan, then tear-free change mid-frame, then leading-zero blanking.
      run = 1'b1;
      step();
      frame_check("f1234", 16'h1234, 4'b0000, 4'b1111, 16'h1234, 4'b0000, 1'b0);
      frame_check("tear", 16'h1234, 4'b0000, 4'b1111, 16'h5678, 4'b0000, 1'b0);
      frame_check("f5678", 16'h5678, 4'b0000, 4'b1111, 16'h0045, 4'b0000, 1'b1);
      frame_check("lz0045", 16'h0045, 4'b0000, 4'b0011, 16'h0000, 4'b0000, 1'b1);
      frame_check("lz0000", 16'h0000, 4'b0000, 4'b0001, 16'h1234, 4'b0100, 1'b0);
      frame_check("dp", 16'h1234, 4'b0100, 4'b1111, 16'h9876, 4'b0100, 1'b0);

      // Drop run during slot 1 drive phase.
      for (int i = 0; i < 13; i++) begin
         check($sformatf("pre-drop sel %0d", i), a_sel, (i < 8) ? 0 : 1);
         step();
      end
      check("pre-drop a_ena", a_ena, 1);
      check("pre-drop a_digit", a_digit, 4'h7);
      data = 16'h4321;
      run  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_idle($sformatf("drop %0d", i));
      end
      run = 1'b1;
      step();
      frame_check("rerun", 16'h4321, 4'b0100, 4'b1111, 16'h4321, 4'b0100, 1'b0);

      // Reset mid-drive with run held high.
      for (int i = 0; i < 4; i++) step();
      check("pre-rst a_ena", a_ena, 1);
      rst = 1'b1;
      step();
      check("midrst a_sel", a_sel, 0);
      check("midrst a_ena", a_ena, 0);
      check("midrst a_digit", a_digit, 0);
      check("midrst a_dp", a_dp, 0);
      check("midrst a_frame", a_frame, 0);
      check("midrst b_ena", b_ena, 0);
      step();
      check_idle("rst held");
      rst  = 1'b0;
      data = 16'h2468;
      dp   = 4'b0001;
      step();
      frame_check("postrst", 16'h2468, 4'b0001, 4'b1111, 16'h2468, 4'b0001, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit 7-segment display.
- Steps the digit select/enable that drive the 1-to-4 digit demux.
- Inserts a blanking gap between digits to suppress ghosting.
- Presents the current BCD nibble and decimal point to the segment decoder.
- Snapshots display data once per frame so the display never tears mid-frame.

Parameters:
PRESCALE, 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz); must be >= 2
BLANK, 2000, cycles at the start of each slot with o_ena low; 0 <= BLANK < PRESCALE

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_run  in  1  display scan enable
i_data  in  16  four BCD digits; [3:0] = digit 0 (least significant) ... [15:12] = digit 3
i_dp  in  4  decimal point per digit, bit n = digit n
i_lzb  in  1  leading-zero blanking enable
o_sel  out  2  digit select to the demux
o_ena  out  1  demux enable; digit n is lit when high
o_digit  out  4  BCD nibble of the selected digit (from the snapshot)
o_dp  out  1  decimal point of the selected digit (from the snapshot)
o_frame  out  1  one-cycle pulse marking the end of a full 4-digit frame

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state changes occur on the rising edge of i_clk.
- Reset values: o_sel=0, o_ena=0, o_digit=0, o_dp=0, o_frame=0. State=S_OFF, slot counter=0, snapshot=0.
- Reset has priority over everything, including mid-slot operation.
- Outputs: all registered.
- Slot counter: cnt, width $clog2(PRESCALE), runs 0..PRESCALE-1 within each slot.
- States: S_OFF, S_BLANK, S_DRIVE.
- S_OFF:
  - o_ena=0, o_sel=0, cnt held at 0.
  - On the edge where i_run=1 is sampled: enter S_BLANK with cnt=0, o_sel=0, and load the snapshot from i_data/i_dp/i_lzb.
- S_BLANK:
  - o_ena=0.
  - When cnt reaches BLANK-1, move to S_DRIVE.
  - If BLANK=0, S_BLANK is skipped and the slot enters S_DRIVE directly.
- S_DRIVE:
  - o_ena=1 unless the current digit is leading-zero blanked.
  - At cnt=PRESCALE-1: cnt wraps to 0, o_sel increments (3 wraps to 0), return to S_BLANK.
- Slot timing: each slot lasts exactly PRESCALE cycles; o_ena is high for exactly PRESCALE-BLANK consecutive cycles per unblanked slot.
- Frame end (last cycle of slot 3, cnt=PRESCALE-1):
  - o_frame=1 for that single cycle.
  - Snapshot reloads on the same edge that starts slot 0.
  - No other event changes the snapshot.
- o_digit/o_dp: reflect snapshot nibble/bit o_sel for the whole slot, including the blank phase.
- Leading-zero blanking (snapshot i_lzb=1):
  - Digit 3 blanked if nibble3=0.
  - Digit 2 blanked if nibbles 3 and 2 are 0.
  - Digit 1 blanked if nibbles 3, 2 and 1 are 0.
  - Digit 0 is never blanked.
  - Blanked slots keep full timing with o_ena=0.
- Non-BCD nibbles (>9): passed through unchanged; no blanking effect unless the value is 0.
- i_run=0 sampled in any state:
  - Next edge enters S_OFF: o_ena=0, o_sel=0, cnt=0, o_frame=0.
  - The frame is abandoned; no o_frame pulse.
- Re-enable: restarts at slot 0 with a fresh snapshot.

Decomposition:
- Shared display package holds:
  - State encoding (S_OFF/S_BLANK/S_DRIVE).
  - NUM_DIGITS=4 and DIGIT_W=4.
  - Default PRESCALE/BLANK constants for the 100 MHz board clock.
- One natural sub-module: scan_slot_timer.
  - Parameterised PRESCALE/BLANK counter.
  - Outputs: blank-done and slot-done strobes.
- The FSM, snapshot and blanking logic stay in seg_scan_ctrl.
- The demux is instantiated by the parent, not inside this block.

Test Plan:
1. Reset with i_run=1 held mid-S_DRIVE -> next edge: all outputs 0, state S_OFF; after release, scan starts at slot 0.
2. PRESCALE=8, BLANK=2, i_data=16'h1234, i_lzb=0, i_run=1 -> o_sel 0,1,2,3 for 8 cycles each; o_ena high on cnt 2..7; o_digit 4,3,2,1; o_frame high only at slot 3 cnt 7.
3. Tear-free load: change i_data 16'h1234->16'h5678 during slot 1 -> digits 3,2,1 still shown for rest of frame; next frame shows 8,7,6,5.
4. Leading-zero blanking, i_lzb=1:
   - i_data=16'h0045 -> slots 2,3 have o_ena=0 for all 8 cycles; slots 0,1 show 5,4.
   - i_data=16'h0000 -> only slot 0 lit, showing 0.
5. BLANK=0 -> o_ena high all 8 cycles of each slot. i_dp=4'b0100 -> o_dp=1 only while o_sel=2.
6. Drop i_run during slot 1 S_DRIVE -> next edge: o_ena=0, o_sel=0, no o_frame. Re-raise -> slot 0 restarts at cnt 0 with a new snapshot.
